// File: rtl/param_barrel_shift_pipe.sv
// param_barrel_shift_pipe: pipelined barrel shifter/rotator with valid/ready.
// Stage k resolves amount bit k (a shift/rotate of 2^k). Latency is SHAMT_W cycles.
// Modes: 00 rotl, 01 rotr, 10 shl logical, 11 shr.
// Optional macro SHIFT_ARITH_EN: mode 11 becomes an arithmetic right shift that
// fills with the operand MSB captured at acceptance. Without the macro, mode 11
// is a logical right shift that fills with zeros.
module param_barrel_shift_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int unsigned STAGES = SHAMT_W;

  localparam logic [1:0] MODE_ROTL = 2'b00;
  localparam logic [1:0] MODE_ROTR = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  logic stall;

  // One fixed-distance step: shift or rotate d by sh when en is set.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             en,
    input int unsigned      sh,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] fill_mask;
    fill_mask = {WIDTH{fill}} << (WIDTH - sh);
    r = d;
    if (en) begin
      case (mode)
        MODE_ROTL: r = (d << sh) | (d >> (WIDTH - sh));
        MODE_ROTR: r = (d >> sh) | (d << (WIDTH - sh));
        MODE_SHL:  r = d << sh;
        MODE_SHR:  r = (d >> sh) | fill_mask;
        default:   r = d;
      endcase
    end
    return r;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SH    = 32'(1) << k;
    localparam int unsigned SRC_W = SHAMT_W - k;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [1:0]       src_mode;
    logic [SRC_W-1:0] src_amt;
    logic             src_fill;

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    if (k == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_data  = in_data;
      assign src_mode  = in_mode;
      assign src_amt   = in_amount;
`ifdef SHIFT_ARITH_EN
      assign src_fill  = in_data[WIDTH-1];
`else
      assign src_fill  = 1'b0;
`endif
    end else begin : g_src_prev
      assign src_valid = g_stage[k-1].valid_q;
      assign src_data  = g_stage[k-1].data_q;
      assign src_mode  = g_stage[k-1].g_fwd.mode_q;
      assign src_amt   = g_stage[k-1].g_fwd.amt_q;
`ifdef SHIFT_ARITH_EN
      assign src_fill  = g_stage[k-1].g_fwd.sign_q;
`else
      assign src_fill  = 1'b0;
`endif
    end

    assign data_d = shift_step(src_data, src_mode, src_amt[0], SH, src_fill);

    // Stage data/valid register; holds while the output is back-pressured.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (!stall) begin
        valid_q <= src_valid;
        data_q  <= data_d;
      end
    end

    // Control carried forward to later stages; the last stage needs none.
    if (k < STAGES - 1) begin : g_fwd
      logic [1:0]         mode_q;
      logic [SRC_W-2:0]   amt_q;
`ifdef SHIFT_ARITH_EN
      logic               sign_q;
`endif

      // Remaining amount bits and mode travel with the data.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          mode_q <= '0;
          amt_q  <= '0;
`ifdef SHIFT_ARITH_EN
          sign_q <= 1'b0;
`endif
        end else if (!stall) begin
          mode_q <= src_mode;
          amt_q  <= src_amt[SRC_W-1:1];
`ifdef SHIFT_ARITH_EN
          sign_q <= src_fill;
`endif
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_data  = g_stage[STAGES-1].data_q;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

endmodule

// File: tb/tb_param_barrel_shift_pipe.sv
// Bench for param_barrel_shift_pipe (WIDTH=8): directed cases, back-pressure,
// reset flush and randomized traffic against a behavioural reference model.
module tb_param_barrel_shift_pipe;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHAMT_W = 3;
  localparam int          LAT     = 3;
`ifdef SHIFT_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_amount;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  param_barrel_shift_pipe #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_vec;
  int         n_err;
  int         cyc;
  int         n_acc;
  bit         lat_chk;
  logic [7:0] drv_exp;
  bit         prev_stall;
  logic [7:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: rotate/shift by whole amount using double-width words and shifts.
  function automatic logic [7:0] ref_op(input logic [7:0] d, input int a, input logic [1:0] m);
    logic [15:0]       dd;
    logic signed [7:0] s;
    dd = {d, d};
    s  = d;
    case (m)
      2'b00: begin dd = dd << a; return dd[15:8]; end
      2'b01: begin dd = dd >> a; return dd[7:0];  end
      2'b10: return 8'(d << a);
      default: begin
        if (ARITH) return 8'(s >>> a);
        else       return 8'(d >> a);
      end
    endcase
  endfunction

  // Evaluate handshakes at negedge, then advance to just after the next posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(LAT));
        end
      end
      if (out_valid && !out_ready) begin
        if (prev_stall) check("hold_data", 32'(out_data), 32'(held));
        held       = out_data;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.data = drv_exp;
        e.cyc  = cyc;
        sb.push_back(e);
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                       input logic [7:0] e);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = a;
    in_mode   = m;
    drv_exp   = e;
    cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() > 0; i++) cycle();
    check("drain_empty", 32'(sb.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    int cnt;
    int base;
    int guard;
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;

    n_vec = 0; n_err = 0; cyc = 0; n_acc = 0;
    lat_chk = 1'b1; prev_stall = 1'b0; held = '0; drv_exp = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0; in_mode = '0;
    out_ready = 1'b1;

    // Reset state
    cycle(); cycle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    rst_n = 1'b1;
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Case 1: 0x66 amt5 in every mode, back to back
    drive(8'h66, 3'd5, 2'b00, 8'hCC);
    drive(8'h66, 3'd5, 2'b01, 8'h33);
    drive(8'h66, 3'd5, 2'b10, 8'hC0);
    drive(8'h66, 3'd5, 2'b11, 8'h03);
    idle(6);

    // Case 2: extreme amounts, MSB-set operand, amount 0
    drive(8'h23, 3'd7, 2'b00, 8'h91);
    drive(8'h23, 3'd7, 2'b01, 8'h46);
    drive(8'hC7, 3'd2, 2'b00, 8'h1F);
    drive(8'hC7, 3'd2, 2'b01, 8'hF1);
    drive(8'hC7, 3'd2, 2'b10, 8'h1C);
    drive(8'hC7, 3'd2, 2'b11, ARITH ? 8'hF1 : 8'h31);
    for (int mm = 0; mm < 4; mm++) drive(8'hC7, 3'd0, 2'(mm), 8'hC7);
    idle(6);

    // Case 3: 8 random ops on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      drive(d, a, m, ref_op(d, int'(a), m));
    end
    drain(20);

    // Case 4: back-pressure fills exactly STAGES entries
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20 && in_ready; i++) begin
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      cnt++;
      drive(d, a, m, ref_op(d, int'(a), m));
    end
    check("held_count",    32'(cnt),      32'd3);
    check("stall_inready", 32'(in_ready), 32'd0);
    idle(5);
    check("stall_pending", 32'(sb.size()), 32'd3);
    drain(20);

    // Case 5: random traffic with random back-pressure
    base  = n_acc;
    guard = 0;
    while ((n_acc - base) < 200 && guard < 4000) begin
      d = 8'($urandom); a = 3'($urandom); m = 2'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = d;
      in_amount = a;
      in_mode   = m;
      drv_exp   = ref_op(d, int'(a), m);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
      guard++;
    end
    check("rand_accepted", 32'(n_acc - base), 32'd200);
    drain(50);

    // Case 6: reset with ops in flight
    lat_chk = 1'b1;
    drive(8'h11, 3'd1, 2'b00, 8'h22);
    drive(8'h81, 3'd1, 2'b01, 8'hC0);
    drive(8'h0F, 3'd4, 2'b10, 8'hF0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cycle();
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data",  32'(out_data),  32'd0);
    sb.delete();
    cycle();
    rst_n = 1'b1;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    idle(6);
    drive(8'h66, 3'd5, 2'b00, 8'hCC);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
